stim_driver: RTL and testbench

STIM_DRIVER -- requirements
Module: stim_driver

---
 rtl/stim_driver.sv | 146 ++++++++++++++
 tb/tb_stim_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_driver.sv
// stim_driver: steps a WIDTH-bit pattern counter across every input combination
// of a simple device, lets each pattern settle, then samples the synchronized
// device response and scores it against the expected inverter/buffer model.
//
// Timeline per pattern: SETTLE cycles in SETTLE, then one SAMPLE cycle.
// A full pass is therefore 2^WIDTH * (SETTLE+1) cycles from the first
// SETTLE cycle to done=1.
//
// There is no valid/ready handshake in this block. The start input is a
// level-sampled request. It only has an effect in IDLE or DONE. It is ignored
// while busy.
module stim_driver #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 16,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop,
    input  logic [WIDTH-1:0] sense,
    output logic [WIDTH-1:0] drive,
    output logic [WIDTH-1:0] expected,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]       ERR_MAX     = 8'hFF;
    localparam logic [WIDTH-1:0] ALL_ONES    = '1;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] drive_q, drive_d;
    logic [7:0]       err_q, err_d;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic             mismatch;

    // Two-flop synchronizer: sense is asynchronous to clk, only sync2_q is used.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sense;
            sync2_q <= sync1_q;
        end
    end

    // State, pattern, settle counter and scoring registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drive_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drive_q <= drive_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    // The response model has zero latency: it follows the registered drive value.
    assign expected = (INVERT != 0) ? ~drive_q : drive_q;
    assign mismatch = (sync2_q != expected);

    // Next-state logic: settle, sample/score, advance or wrap, finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drive_d = drive_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    drive_d = '0;
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Only the first mismatch since start is remembered. The
                // error count sticks at its maximum.
                if (mismatch) begin
                    if (err_q == 8'd0) begin
                        ff_d = drive_q;
                    end
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 8'd1;
                    end
                end
                if (drive_q != ALL_ONES) begin
                    drive_d = drive_q + WIDTH'(1);
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (loop) begin
                    // Loop is only looked at here, in the last sample of a pass.
                    drive_d = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign drive      = drive_q;
    assign sample     = (state_q == S_SAMPLE);
    assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done       = (state_q == S_DONE);
    assign pass       = (state_q == S_DONE) && (err_q == 8'd0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_stim_driver.sv
// Bench for stim_driver (WIDTH=6, SETTLE=4). The main instance is an inverter
// tester. A second instance with INVERT=0 covers the buffer configuration.
// Device behaviour is selected by "mode". The expected scores come from a
// table or from a pattern-level model that walks every pass.
module tb_stim_driver;

    localparam int W = 6;
    localparam int ST = 4;
    localparam int PER_PASS = 64 * (ST + 1);

    logic         clk, rst, start, loop;
    logic [W-1:0] sense, drive, expected, first_fail;
    logic         sample, busy, done, pass;
    logic [7:0]   err_count;
    logic [1:0]   dbg_state;

    logic         start2;
    logic [W-1:0] sense2, drive2, expected2, first_fail2;
    logic         sample2, busy2, done2, pass2;
    logic [7:0]   err_count2;
    logic [1:0]   dbg_state2;

    int           mode;
    logic [W-1:0] fault_mask [64];
    int           errors = 0;
    int           checks = 0;

    stim_driver #(.WIDTH(W), .SETTLE(ST), .INVERT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .sense(sense),
        .drive(drive), .expected(expected), .sample(sample), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .dbg_state(dbg_state)
    );

    stim_driver #(.WIDTH(W), .SETTLE(ST), .INVERT(0)) dut_buf (
        .clk(clk), .rst(rst), .start(start2), .loop(1'b0), .sense(sense2),
        .drive(drive2), .expected(expected2), .sample(sample2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err_count2),
        .first_fail(first_fail2), .dbg_state(dbg_state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device models: 0 good inverter, 1 bit 2 stuck low, 2 all pins high,
    // 3 buffer-like (sense=drive), 4 inverter with per-pattern faults.
    function automatic logic [W-1:0] sense_of(input int m, input logic [W-1:0] d,
                                              input logic [W-1:0] f);
        case (m)
            0: return ~d;
            1: return ~d & 6'h3B;
            2: return 6'h3F;
            3: return d;
            4: return ~d ^ f;
            default: return ~d;
        endcase
    endfunction

    always_comb sense = sense_of(mode, drive, fault_mask[drive]);
    assign sense2 = drive2;

    // Model: score every pattern of every pass as an inverter tester would.
    task automatic model(input int m, input int passes, output int err, output int ff);
        logic [W-1:0] d;
        err = 0;
        ff = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 64; i++) begin
                d = W'(i);
                if (sense_of(m, d, fault_mask[i]) != ~d) begin
                    if (err == 0) ff = i;
                    if (err < 255) err++;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drivers: start pulse, then follow the run sample by sample until done.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge inside the first SETTLE cycle (cycle 0).
    task automatic monitor(input int passes, input int start_at, output int cyc,
                           output int nsamp, output int space_bad, output int seq_bad);
        int wraps;
        bit poked;
        cyc = 0;
        nsamp = 0;
        space_bad = 0;
        seq_bad = 0;
        wraps = 0;
        poked = 0;
        while (!done && cyc < passes * PER_PASS + 50) begin
            if (wraps >= passes - 1) loop = 1'b0;
            if (start_at >= 0 && !poked && busy && !sample && int'(drive) == start_at) begin
                start = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            if (sample) begin
                if (cyc % (ST + 1) != ST) space_bad++;
                if (int'(drive) != nsamp % 64) seq_bad++;
                nsamp++;
                if (drive == 6'h3F) wraps++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        loop = 1'b0;
    endtask

    task automatic score_run(input int passes, input int start_at, input int exp_err,
                             input int exp_ff, input int exp_pass);
        int cyc, nsamp, sb, qb;
        int e0, f0;
        loop = (passes > 1);
        pulse_start();
        monitor(passes, start_at, cyc, nsamp, sb, qb);
        check("done_reached", int'(done), 1);
        check("pass_cycles", cyc, passes * PER_PASS);
        check("sample_count", nsamp, passes * 64);
        check("sample_spacing", sb, 0);
        check("drive_sequence", qb, 0);
        check("err_count", int'(err_count), exp_err);
        check("first_fail", int'(first_fail), exp_ff);
        check("pass", int'(pass), exp_pass);
        check("drive_held", int'(drive), 63);
        e0 = int'(err_count);
        f0 = int'(first_fail);
        repeat (8) @(negedge clk);
        check("done_stable", int'(done), 1);
        check("err_stable", int'(err_count), e0);
        check("ff_stable", int'(first_fail), f0);
    endtask

    typedef struct {
        int mode;
        int passes;
        int start_at;
        int exp_err;
        int exp_ff;
        int exp_pass;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, nsamp, sb, qb, me, mf, n;
        rst = 1'b0;
        start = 1'b0;
        loop = 1'b0;
        start2 = 1'b0;
        mode = 0;
        for (int i = 0; i < 64; i++) fault_mask[i] = '0;

        // Reset state
        #1;
        check("rst_drive", int'(drive), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_state", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_waits", int'(busy), 0);

        // Table-driven single-pass runs; start pokes mid-pass must be ignored.
        vecs[0] = '{0, 1, -1, 0, 0, 1};
        vecs[1] = '{1, 1, -1, 32, 0, 0};
        vecs[2] = '{3, 1, -1, 64, 0, 0};
        vecs[3] = '{2, 1, -1, 63, 1, 0};
        vecs[4] = '{0, 1, 10, 0, 0, 1};
        vecs[5] = '{1, 1, 10, 32, 0, 0};
        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            score_run(vecs[v].passes, vecs[v].start_at, vecs[v].exp_err,
                      vecs[v].exp_ff, vecs[v].exp_pass);
        end

        // All pins high over five looped passes: the count saturates.
        mode = 2;
        score_run(5, -1, 255, 1, 0);

        // Randomized per-pattern faults against the model.
        for (int r = 0; r < 3; r++) begin
            mode = 4;
            for (int i = 0; i < 64; i++)
                fault_mask[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 63)) : '0;
            n = $urandom_range(1, 2);
            model(4, n, me, mf);
            score_run(n, -1, me, mf, (me == 0) ? 1 : 0);
        end

        // Reset mid-pass at pattern 30, during SETTLE.
        mode = 1;
        pulse_start();
        n = 0;
        while (!(busy && !sample && drive == 6'd30) && n < PER_PASS) begin
            @(negedge clk);
            n++;
        end
        check("reached_p30", int'(drive), 30);
        check("err_before_rst", int'(err_count), 16);
        #2 rst = 1'b0;
        #1;
        check("abort_drive", int'(drive), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sample", int'(sample), 0);
        check("abort_err", int'(err_count), 0);
        check("abort_ff", int'(first_fail), 0);
        check("abort_state", int'(dbg_state), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        // Release reset with start already high: the first edge starts a pass.
        rst = 1'b0;
        @(negedge clk);
        mode = 0;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_release", int'(busy), 1);
        check("restart_drive", int'(drive), 0);
        monitor(1, -1, cyc, nsamp, sb, qb);
        check("restart_cycles", cyc, PER_PASS);
        check("restart_pass", int'(pass), 1);
        check("restart_err", int'(err_count), 0);

        // Buffer configuration with a good buffer part.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < PER_PASS + 50) begin
            @(negedge clk);
            n++;
        end
        check("buf_done", int'(done2), 1);
        check("buf_pass", int'(pass2), 1);
        check("buf_err", int'(err_count2), 0);
        check("buf_expected", int'(expected2), 63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
